// File: rtl/prio_enc8_hs_if.sv
// Request/acknowledge bus of the registered 8-input priority encoder.
// The master drives requests and ACK; the slave presents CODE/VALID and status.
interface prio_enc8_hs_if;
  logic       ei_l;
  logic [7:0] i_l;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       gs_l;
  logic       eo_l;
  logic [7:0] pend;
  logic [7:0] svc_cnt;

  modport master (
    output ei_l, i_l, ack,
    input  code, valid, gs_l, eo_l, pend, svc_cnt
  );

  modport slave (
    input  ei_l, i_l, ack,
    output code, valid, gs_l, eo_l, pend, svc_cnt
  );
endinterface

// File: rtl/prio_enc8_hs.sv
// Registered 74x148-style priority encoder with a pending register and a
// request/acknowledge handshake; the highest pending line is served first.
module prio_enc8_hs #(
  parameter bit STICKY = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  prio_enc8_hs_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RECOV = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_req;
  logic [7:0] r_pend;
  logic [2:0] r_code;
  logic       r_valid;
  logic       r_gs_l;
  logic       r_eo_l;
  logic [7:0] r_svc_cnt;

  logic [7:0] w_req_nxt;
  logic [7:0] w_clr;
  logic [7:0] w_pend_nxt;
  logic       w_eo_l_nxt;

  function automatic logic [2:0] f_top_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Next-state request, clear mask, pending vector and cascade enable.
  always_comb begin
    w_req_nxt  = 8'h00;
    w_clr      = 8'h00;
    w_pend_nxt = 8'h00;
    w_eo_l_nxt = 1'b1;
    if (bus.ei_l == 1'b0) begin
      w_req_nxt = ~bus.i_l;
    end else begin
      w_req_nxt = 8'h00;
    end
    if (r_valid && bus.ack) begin
      w_clr = 8'(8'h01 << r_code);
    end else begin
      w_clr = 8'h00;
    end
    // Set wins over clear: a line still held after ACK re-pends at once.
    if (STICKY) begin
      w_pend_nxt = (r_pend & ~w_clr) | r_req;
    end else begin
      w_pend_nxt = r_req;
    end
    w_eo_l_nxt = ~(~bus.ei_l & (&bus.i_l) & ~(|w_pend_nxt));
  end

  // Input capture, pending register and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req  <= 8'h00;
      r_pend <= 8'h00;
      r_gs_l <= 1'b1;
      r_eo_l <= 1'b1;
    end else begin
      r_req  <= w_req_nxt;
      r_pend <= w_pend_nxt;
      r_gs_l <= ~(|w_pend_nxt);
      r_eo_l <= w_eo_l_nxt;
    end
  end

  // Handshake FSM: present, hold without preemption, one-cycle recovery.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_code    <= 3'd0;
      r_valid   <= 1'b0;
      r_svc_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend != 8'h00) begin
            r_code  <= f_top_idx(r_pend);
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (bus.ack) begin
            r_valid   <= 1'b0;
            r_svc_cnt <= r_svc_cnt + 8'd1;
            r_state   <= ST_RECOV;
          end else begin
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_RECOV: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.code    = r_code;
  assign bus.valid   = r_valid;
  assign bus.gs_l    = r_gs_l;
  assign bus.eo_l    = r_eo_l;
  assign bus.pend    = r_pend;
  assign bus.svc_cnt = r_svc_cnt;

endmodule

// File: tb/tb_prio_enc8_hs.sv
// Bench for prio_enc8_hs: a sticky and a non-sticky instance share stimulus
// and are compared every cycle against a behavioural model of the handshake.
module tb_prio_enc8_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_ei_l;
  logic [7:0] tb_i_l;
  logic       tb_ack;

  int checks = 0;
  int errors = 0;

  prio_enc8_hs_if if0 ();
  prio_enc8_hs_if if1 ();

  assign if0.ei_l = tb_ei_l;
  assign if0.i_l  = tb_i_l;
  assign if0.ack  = tb_ack;
  assign if1.ei_l = tb_ei_l;
  assign if1.i_l  = tb_i_l;
  assign if1.ack  = tb_ack;

  prio_enc8_hs #(.STICKY(1'b1)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  prio_enc8_hs #(.STICKY(1'b0)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] m_req   [2] = '{8'h00, 8'h00};
  logic [7:0] m_pend  [2] = '{8'h00, 8'h00};
  int         m_code  [2] = '{0, 0};
  bit         m_valid [2] = '{1'b0, 1'b0};
  int         m_blank [2] = '{0, 0};
  int         m_cnt   [2] = '{0, 0};
  bit         m_gs_l  [2] = '{1'b1, 1'b1};
  bit         m_eo_l  [2] = '{1'b1, 1'b1};
  int         m_hs = 0;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_req[d] = 8'h00; m_pend[d] = 8'h00; m_code[d] = 0; m_valid[d] = 1'b0;
        m_blank[d] = 0; m_cnt[d] = 0; m_gs_l[d] = 1'b1; m_eo_l[d] = 1'b1;
      end
      m_hs = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [7:0] req_new, pend_new, clr;
        bit accept;
        req_new  = tb_ei_l ? 8'h00 : ~tb_i_l;
        accept   = m_valid[d] && tb_ack;
        clr      = accept ? (8'h01 << m_code[d]) : 8'h00;
        pend_new = (d == 0) ? ((m_pend[d] & ~clr) | m_req[d]) : m_req[d];
        if (m_valid[d]) begin
          if (tb_ack) begin
            m_valid[d] = 1'b0;
            m_cnt[d]   = (m_cnt[d] + 1) % 256;
            m_blank[d] = 1;
            if (d == 0) m_hs++;
          end
        end else if (m_blank[d] > 0) begin
          m_blank[d]--;
        end else if (m_pend[d] != 8'h00) begin
          m_code[d]  = highest(m_pend[d]);
          m_valid[d] = 1'b1;
        end
        m_gs_l[d] = (pend_new == 8'h00);
        m_eo_l[d] = !(tb_ei_l == 1'b0 && tb_i_l == 8'hFF && pend_new == 8'h00);
        m_req[d]  = req_new;
        m_pend[d] = pend_new;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [2:0] code, input logic valid,
                         input logic gs_l, input logic eo_l, input logic [7:0] pend,
                         input logic [7:0] cnt);
    chk($sformatf("dut%0d_valid", d), 32'(valid), 32'(m_valid[d]));
    chk($sformatf("dut%0d_code", d),  32'(code),  32'(m_code[d]));
    chk($sformatf("dut%0d_gs_l", d),  32'(gs_l),  32'(m_gs_l[d]));
    chk($sformatf("dut%0d_eo_l", d),  32'(eo_l),  32'(m_eo_l[d]));
    chk($sformatf("dut%0d_pend", d),  32'(pend),  32'(m_pend[d]));
    chk($sformatf("dut%0d_cnt", d),   32'(cnt),   32'(m_cnt[d]));
  endtask

  // Compare process: both instances against the model, away from the active edge.
  always @(negedge clk) begin
    cmp_dut(0, if0.code, if0.valid, if0.gs_l, if0.eo_l, if0.pend, if0.svc_cnt);
    cmp_dut(1, if1.code, if1.valid, if1.gs_l, if1.eo_l, if1.pend, if1.svc_cnt);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n = 1'b0; tb_i_l = 8'hFF; tb_ei_l = 1'b0; tb_ack = 1'b0;
    step(2);
    chk("rst_valid", 32'(if0.valid), 32'd0);
    chk("rst_gs_l",  32'(if0.gs_l),  32'd1);
    chk("rst_eo_l",  32'(if0.eo_l),  32'd1);
    chk("rst_pend",  32'(if0.pend),  32'd0);
    rst_n = 1'b1;
    step(1);
    chk("idle_eo_l", 32'(if0.eo_l),    32'd0);
    chk("idle_code", 32'(if0.code),    32'd0);
    chk("idle_cnt",  32'(if0.svc_cnt), 32'd0);

    // single request on bit 2, one-cycle pulse
    tb_i_l = 8'hFB; step(1);
    tb_i_l = 8'hFF; step(1);
    chk("single_pend", 32'(if0.pend), 32'h04);
    step(1);
    chk("single_valid", 32'(if0.valid), 32'd1);
    chk("single_code",  32'(if0.code),  32'd2);
    step(5);
    chk("single_hold_code", 32'(if0.code), 32'd2);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    chk("single_ack_valid", 32'(if0.valid),   32'd0);
    chk("single_ack_pend",  32'(if0.pend),    32'd0);
    chk("single_ack_cnt",   32'(if0.svc_cnt), 32'd1);
    chk("single_ack_gs_l",  32'(if0.gs_l),    32'd1);
    step(3);

    // priority and no preemption
    tb_i_l = 8'hEE; step(1);
    tb_i_l = 8'hFF; step(2);
    chk("prio_code4", 32'(if0.code), 32'd4);
    tb_i_l = 8'h7F; step(1);
    tb_i_l = 8'hFF; step(2);
    chk("nopreempt_code", 32'(if0.code), 32'd4);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    chk("recov_valid", 32'(if0.valid), 32'd0);
    step(1);
    chk("recov2_valid", 32'(if0.valid), 32'd0);
    step(1);
    chk("prio_code7", 32'(if0.code), 32'd7);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    step(2);
    chk("prio_code0", 32'(if0.code), 32'd0);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    chk("prio_cnt", 32'(if0.svc_cnt), 32'd4);
    step(3);

    // held line re-pends
    tb_i_l = 8'hDF; step(3);
    chk("held_code", 32'(if0.code), 32'd5);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    chk("held_pend", 32'(if0.pend), 32'h20);
    step(2);
    chk("held_again_valid", 32'(if0.valid), 32'd1);
    chk("held_again_code",  32'(if0.code),  32'd5);
    tb_i_l = 8'hFF; step(1);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    chk("held_release_pend", 32'(if0.pend), 32'h00);
    step(3);

    // enable gating and spurious ACK
    tb_ei_l = 1'b1; tb_i_l = 8'h00; step(3);
    chk("gate_pend",  32'(if0.pend),  32'd0);
    chk("gate_eo_l",  32'(if0.eo_l),  32'd1);
    chk("gate_valid", 32'(if0.valid), 32'd0);
    tb_ack = 1'b1; step(2); tb_ack = 1'b0;
    chk("spurious_cnt", 32'(if0.svc_cnt), 32'd6);
    tb_ei_l = 1'b0; step(3);
    chk("gate_open_code", 32'(if0.code), 32'd7);
    tb_i_l = 8'hFF; tb_ack = 1'b1; step(30); tb_ack = 1'b0;
    step(3);

    // non-sticky instance: a one-cycle pulse is still presented and held
    tb_i_l = 8'hFD; step(1);
    tb_i_l = 8'hFF; step(2);
    chk("ns_valid", 32'(if1.valid), 32'd1);
    chk("ns_code",  32'(if1.code),  32'd1);
    step(4);
    chk("ns_hold_code", 32'(if1.code), 32'd1);
    chk("ns_hold_pend", 32'(if1.pend), 32'd0);
    tb_ack = 1'b1; step(1); tb_ack = 1'b0;
    step(3);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      tb_i_l  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      tb_ei_l = ($urandom_range(0, 7) == 0);
      tb_ack  = 1'($urandom_range(0, 1));
      step(1);
    end
    tb_ack = 1'b0; tb_ei_l = 1'b0; tb_i_l = 8'hFF;

    // counter wrap: 256 handshakes from reset
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    tb_i_l = 8'h7F; tb_ack = 1'b1;
    guard = 0;
    while (m_hs < 256 && guard < 2000) begin
      step(1);
      guard++;
    end
    chk("wrap_timeout", 32'(guard < 2000), 32'd1);
    chk("wrap_cnt0", 32'(if0.svc_cnt), 32'd0);
    chk("wrap_cnt1", 32'(if1.svc_cnt), 32'd0);

    // asynchronous reset while VALID=1
    tb_ack = 1'b0;
    guard = 0;
    while (!m_valid[0] && guard < 20) begin
      step(1);
      guard++;
    end
    chk("prereset_valid", 32'(if0.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid0", 32'(if0.valid), 32'd0);
    chk("async_rst_valid1", 32'(if1.valid), 32'd0);
    chk("async_rst_pend",   32'(if0.pend),  32'd0);
    step(2);
    tb_i_l = 8'hFF; rst_n = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
